// File: rtl/gat_bram_load_bridge_pkg.sv
// Shared constants and channel identifiers for the host BRAM load bridge.
package gat_bram_load_bridge_pkg;

    localparam int unsigned GAT_TOP_WIDTH   = 32;
    localparam int unsigned GAT_NUM_CH      = 4;
    localparam int unsigned GAT_MAX_DATA_W  = 103;
    localparam int unsigned GAT_INT_ADDR_W  = 18;
    localparam int unsigned GAT_HOST_ADDR_W = 20;
    localparam int unsigned GAT_RD_BEATS    = 4;
    localparam int unsigned GAT_RD_LAT      = 2;

    // Beats per internal word, 3 bits per channel, channel 0 in the LSBs.
    localparam logic [3*GAT_NUM_CH-1:0] GAT_CH_BEATS = {3'd2, 3'd1, 3'd1, 3'd1};

    typedef enum logic [1:0] {
        CH_H_DATA    = 2'd0,
        CH_NODE_INFO = 2'd1,
        CH_WGT       = 2'd2,
        CH_SUBGRAPH  = 2'd3
    } ch_id_e;

endpackage

// File: rtl/gat_bram_load_bridge_packer.sv
// Single write channel: checks host word order, packs beats into one wide
// word, issues the internal write and tracks ready / error state.
module gat_bram_load_bridge_packer
    import gat_bram_load_bridge_pkg::*;
#(
    parameter int unsigned TOP_WIDTH  = GAT_TOP_WIDTH,
    parameter int unsigned MAX_DATA_W = GAT_MAX_DATA_W,
    parameter int unsigned INT_ADDR_W = GAT_INT_ADDR_W,
    parameter int unsigned WA_W       = GAT_HOST_ADDR_W - 2,
    parameter int unsigned BEATS      = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  beat_valid,
    input  logic [WA_W-1:0]       beat_wa,
    input  logic [TOP_WIDTH-1:0]  beat_data,
    input  logic                  load_done,
    output logic [MAX_DATA_W-1:0] wr_din,
    output logic                  wr_ena,
    output logic [INT_ADDR_W-1:0] wr_addra,
    output logic                  ready,
    output logic                  err,
    output logic [INT_ADDR_W-1:0] words
);

    localparam logic [2:0] LAST_B = 3'(BEATS - 1);

    logic [2:0]            b, b_nx, cur_b;
    logic [WA_W-1:0]       exp, exp_nx;
    logic [MAX_DATA_W-1:0] packer, packer_nx, base;
    logic [INT_ADDR_W-1:0] count, count_nx, cur_count;
    logic                  sat, sat_nx;
    logic                  err_nx, ready_nx, done_q;
    logic                  take, start, emit;

    assign words = count;

    // Beat acceptance, lane packing and the load-done rule (applied after the beat).
    always_comb begin
        b_nx      = b;
        exp_nx    = exp;
        packer_nx = packer;
        count_nx  = count;
        sat_nx    = sat;
        err_nx    = err;
        ready_nx  = ready;
        take      = 1'b0;
        start     = 1'b0;
        emit      = 1'b0;

        if (beat_valid) begin
            if (ready)                 err_nx = 1'b1;
            else if (beat_wa == '0)    begin take = 1'b1; start = 1'b1; end
            else if (sat)              err_nx = 1'b1;
            else if (beat_wa == exp)   take = 1'b1;
            else                       err_nx = 1'b1;
        end

        // A restart behaves as beat 0 of word 0 on a freshly cleared channel.
        cur_b     = start ? 3'd0 : b;
        cur_count = start ? '0 : count;
        base      = (cur_b == 3'd0) ? '0 : packer;

        if (take) begin
            for (int unsigned i = 0; i < MAX_DATA_W; i++) begin
                packer_nx[i] = (cur_b == 3'(i / TOP_WIDTH)) ? beat_data[i % TOP_WIDTH] : base[i];
            end
            exp_nx   = beat_wa + 1'b1;
            count_nx = cur_count;
            sat_nx   = start ? 1'b0 : sat;
            if (cur_b == LAST_B) begin
                emit = 1'b1;
                b_nx = 3'd0;
                if (cur_count == '1) sat_nx   = 1'b1;
                else                 count_nx = cur_count + 1'b1;
            end else begin
                b_nx = cur_b + 3'd1;
            end
        end

        if (!load_done) begin
            ready_nx = 1'b0;
        end else if (!done_q) begin
            ready_nx = 1'b1;
            if (b_nx != 3'd0) begin
                err_nx = 1'b1;
                b_nx   = 3'd0;
            end
        end
    end

    // Channel state and registered internal write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b        <= '0;
            exp      <= '0;
            packer   <= '0;
            count    <= '0;
            sat      <= 1'b0;
            err      <= 1'b0;
            ready    <= 1'b0;
            done_q   <= 1'b0;
            wr_ena   <= 1'b0;
            wr_din   <= '0;
            wr_addra <= '0;
        end else begin
            b      <= b_nx;
            exp    <= exp_nx;
            packer <= packer_nx;
            count  <= count_nx;
            sat    <= sat_nx;
            err    <= err_nx;
            ready  <= ready_nx;
            done_q <= load_done;
            wr_ena <= emit;
            if (emit) begin
                wr_din   <= packer_nx;
                wr_addra <= cur_count;
            end
        end
    end

endmodule

// File: rtl/gat_bram_load_bridge.sv
// Host-side BRAM bridge: NUM_CH packing write channels plus a pipelined,
// lane-muxed readback of the wide feature BRAM.
module gat_bram_load_bridge
    import gat_bram_load_bridge_pkg::*;
#(
    parameter int unsigned              TOP_WIDTH   = GAT_TOP_WIDTH,
    parameter int unsigned              NUM_CH      = GAT_NUM_CH,
    parameter int unsigned              MAX_DATA_W  = GAT_MAX_DATA_W,
    parameter logic [3*NUM_CH-1:0]      CH_BEATS    = GAT_CH_BEATS,
    parameter int unsigned              INT_ADDR_W  = GAT_INT_ADDR_W,
    parameter int unsigned              HOST_ADDR_W = GAT_HOST_ADDR_W,
    parameter int unsigned              RD_BEATS    = GAT_RD_BEATS,
    parameter int unsigned              RD_LAT      = GAT_RD_LAT
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [TOP_WIDTH-1:0]                      host_din,
    input  logic                                      host_ena,
    input  logic                                      host_wea,
    input  logic [HOST_ADDR_W-1:0]                    host_addra,
    input  logic [$clog2(NUM_CH)-1:0]                 host_ch_sel,
    input  logic [NUM_CH-1:0]                         load_done_i,
    output logic [NUM_CH*MAX_DATA_W-1:0]              ch_din,
    output logic [NUM_CH-1:0]                         ch_ena,
    output logic [NUM_CH*INT_ADDR_W-1:0]              ch_addra,
    output logic [NUM_CH-1:0]                         ch_ready,
    output logic [NUM_CH-1:0]                         ch_err,
    output logic [NUM_CH*INT_ADDR_W-1:0]              ch_words,
    input  logic [HOST_ADDR_W-1:0]                    rd_addrb,
    output logic [HOST_ADDR_W-2-$clog2(RD_BEATS)-1:0] rd_bram_addr,
    input  logic [RD_BEATS*TOP_WIDTH-1:0]             rd_bram_dout,
    output logic [TOP_WIDTH-1:0]                      rd_dout
);

    localparam int unsigned SEL_W = $clog2(NUM_CH);
    localparam int unsigned LW    = $clog2(RD_BEATS);
    localparam int unsigned WA_W  = HOST_ADDR_W - 2;

    logic          beat_acc;
    logic [LW-1:0] lane_pipe [RD_LAT];
    logic          unused_addr_lsbs;

    assign beat_acc         = host_ena & host_wea;
    assign unused_addr_lsbs = ^{host_addra[1:0], rd_addrb[1:0]};

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        gat_bram_load_bridge_packer #(
            .TOP_WIDTH  (TOP_WIDTH),
            .MAX_DATA_W (MAX_DATA_W),
            .INT_ADDR_W (INT_ADDR_W),
            .WA_W       (WA_W),
            .BEATS      (int'(CH_BEATS[3*g +: 3]))
        ) u_packer (
            .clk        (clk),
            .rst_n      (rst_n),
            .beat_valid (beat_acc && (host_ch_sel == SEL_W'(g))),
            .beat_wa    (host_addra[HOST_ADDR_W-1:2]),
            .beat_data  (host_din),
            .load_done  (load_done_i[g]),
            .wr_din     (ch_din[g*MAX_DATA_W +: MAX_DATA_W]),
            .wr_ena     (ch_ena[g]),
            .wr_addra   (ch_addra[g*INT_ADDR_W +: INT_ADDR_W]),
            .ready      (ch_ready[g]),
            .err        (ch_err[g]),
            .words      (ch_words[g*INT_ADDR_W +: INT_ADDR_W])
        );
    end

    assign rd_bram_addr = rd_addrb[HOST_ADDR_W-1:2+LW];

    // Delay the lane index to line up with BRAM data, then register the selected lane.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < RD_LAT; i++) lane_pipe[i] <= '0;
            rd_dout <= '0;
        end else begin
            lane_pipe[0] <= rd_addrb[LW+1:2];
            for (int unsigned i = 1; i < RD_LAT; i++) lane_pipe[i] <= lane_pipe[i-1];
            rd_dout <= rd_bram_dout[lane_pipe[RD_LAT-1]*TOP_WIDTH +: TOP_WIDTH];
        end
    end

endmodule

// File: tb/tb_gat_bram_load_bridge.sv
// Directed bench for gat_bram_load_bridge with default parameters.
module tb_gat_bram_load_bridge;
    import gat_bram_load_bridge_pkg::*;

    localparam int unsigned DW = 103;
    localparam int unsigned AW = 18;

    logic           clk;
    logic           rst_n;
    logic [31:0]    host_din;
    logic           host_ena;
    logic           host_wea;
    logic [19:0]    host_addra;
    logic [1:0]     host_ch_sel;
    logic [3:0]     load_done_i;
    logic [4*DW-1:0] ch_din;
    logic [3:0]     ch_ena;
    logic [4*AW-1:0] ch_addra;
    logic [3:0]     ch_ready;
    logic [3:0]     ch_err;
    logic [4*AW-1:0] ch_words;
    logic [19:0]    rd_addrb;
    logic [15:0]    rd_bram_addr;
    logic [127:0]   rd_bram_dout;
    logic [31:0]    rd_dout;

    int n_assert = 0;
    int n_fail   = 0;

    gat_bram_load_bridge dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .host_din     (host_din),
        .host_ena     (host_ena),
        .host_wea     (host_wea),
        .host_addra   (host_addra),
        .host_ch_sel  (host_ch_sel),
        .load_done_i  (load_done_i),
        .ch_din       (ch_din),
        .ch_ena       (ch_ena),
        .ch_addra     (ch_addra),
        .ch_ready     (ch_ready),
        .ch_err       (ch_err),
        .ch_words     (ch_words),
        .rd_addrb     (rd_addrb),
        .rd_bram_addr (rd_bram_addr),
        .rd_bram_dout (rd_bram_dout),
        .rd_dout      (rd_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Present one accepted beat; returns at the next falling edge.
    task automatic drive_beat(input int unsigned ch, input logic [19:0] addr, input logic [31:0] data);
        host_ena    = 1'b1;
        host_wea    = 1'b1;
        host_ch_sel = 2'(ch);
        host_addra  = addr;
        host_din    = data;
        @(negedge clk);
    endtask

    task automatic idle();
        host_ena = 1'b0;
        host_wea = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int unsigned sg;
        sg           = int'(CH_SUBGRAPH);
        rst_n        = 1'b0;
        host_din     = '0;
        host_ena     = 1'b0;
        host_wea     = 1'b0;
        host_addra   = '0;
        host_ch_sel  = '0;
        load_done_i  = '0;
        rd_addrb     = '0;
        rd_bram_dout = {32'h4444_4444, 32'hDEAD_BEEF, 32'h2222_2222, 32'h1111_1111};
        repeat (2) @(negedge clk);

        check("rst_ena",   128'(ch_ena),   128'h0);
        check("rst_ready", 128'(ch_ready), 128'h0);
        check("rst_err",   128'(ch_err),   128'h0);
        check("rst_words", 128'(ch_words), 128'h0);
        check("rst_din",   128'(ch_din),   128'h0);
        check("rst_addra", 128'(ch_addra), 128'h0);
        check("rst_rdout", 128'(rd_dout),  128'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Two-beat word on the subgraph channel.
        drive_beat(sg, 20'h0, 32'h1111_1111);
        check("t1_no_ena_mid", 128'(ch_ena), 128'h0);
        drive_beat(sg, 20'h4, 32'h0000_0022);
        check("t1_ena",   128'(ch_ena), 128'h8);
        check("t1_addr",  128'(ch_addra[3*AW +: AW]), 128'h0);
        check("t1_din",   128'(ch_din[3*DW +: DW]),   128'h22_1111_1111);
        check("t1_words", 128'(ch_words[3*AW +: AW]), 128'h1);
        idle();
        check("t1_ena_pulse", 128'(ch_ena), 128'h0);
        check("t1_err",       128'(ch_err), 128'h0);

        // Eight back-to-back single-beat words on channel 0.
        for (int unsigned i = 0; i < 8; i++) begin
            drive_beat(0, 20'(i * 4), 32'hA000_0000 + i);
            check("t2_ena",  128'(ch_ena), 128'h1);
            check("t2_addr", 128'(ch_addra[0 +: AW]), 128'(i));
            check("t2_din",  128'(ch_din[0 +: DW]),   128'(32'hA000_0000 + i));
        end
        idle();
        check("t2_words", 128'(ch_words[0 +: AW]), 128'h8);
        check("t2_err",   128'(ch_err), 128'h0);
        check("t2_idle",  128'(ch_ena), 128'h0);

        // Out-of-order beat is dropped and flagged; restart cleared the count.
        drive_beat(sg, 20'h0, 32'h3333_3333);
        check("t3_words_restart", 128'(ch_words[3*AW +: AW]), 128'h0);
        drive_beat(sg, 20'hC, 32'h4444_4444);
        check("t3_no_ena", 128'(ch_ena), 128'h0);
        check("t3_err",    128'(ch_err), 128'h8);
        idle();
        check("t3_no_ena_late", 128'(ch_ena), 128'h0);

        // Load-done with a partial word pending, then a late beat.
        pulse_reset();
        drive_beat(sg, 20'h0, 32'h0000_0055);
        idle();
        load_done_i = 4'b1000;
        @(negedge clk);
        check("t4_ready", 128'(ch_ready), 128'h8);
        check("t4_err",   128'(ch_err),   128'h8);
        check("t4_no_ena", 128'(ch_ena),  128'h0);
        drive_beat(sg, 20'h4, 32'h0000_0066);
        check("t4_drop_ena",   128'(ch_ena), 128'h0);
        check("t4_drop_words", 128'(ch_words[3*AW +: AW]), 128'h0);
        idle();
        load_done_i = 4'b1010;
        @(negedge clk);
        check("t4_ready_clean", 128'(ch_ready), 128'ha);
        check("t4_err_clean",   128'(ch_err),   128'h8);
        load_done_i = 4'b0010;
        @(negedge clk);
        check("t4_ready_fall", 128'(ch_ready), 128'h2);
        load_done_i = 4'b0000;
        @(negedge clk);

        // Asynchronous reset with a word half-packed.
        drive_beat(sg, 20'h0, 32'h0000_0077);
        drive_beat(sg, 20'h4, 32'h0000_0088);
        drive_beat(sg, 20'h8, 32'h0000_0099);
        idle();
        check("t5_pre_words", 128'(ch_words[3*AW +: AW]), 128'h1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_words", 128'(ch_words), 128'h0);
        check("t5_din",   128'(ch_din),   128'h0);
        check("t5_err",   128'(ch_err),   128'h0);
        check("t5_ready", 128'(ch_ready), 128'h0);
        check("t5_addra", 128'(ch_addra), 128'h0);
        check("t5_rdout", 128'(rd_dout),  128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive_beat(sg, 20'h0, 32'hAAAA_0001);
        check("t5_mid", 128'(ch_ena), 128'h0);
        drive_beat(sg, 20'h4, 32'hBBBB_0002);
        check("t5_ena",  128'(ch_ena), 128'h8);
        check("t5_addr", 128'(ch_addra[3*AW +: AW]), 128'h0);
        check("t5_fresh_din", 128'(ch_din[3*DW +: DW]), 128'hBBBB_0002_AAAA_0001);
        idle();

        // Readback latency and lane select.
        check("t6_lane0",    128'(rd_dout),      128'h1111_1111);
        check("t6_addr0",    128'(rd_bram_addr), 128'h0);
        rd_addrb = 20'h18;
        #1;
        check("t6_bram_addr", 128'(rd_bram_addr), 128'h1);
        @(negedge clk);
        check("t6_lat1", 128'(rd_dout), 128'h1111_1111);
        @(negedge clk);
        check("t6_lat2", 128'(rd_dout), 128'h1111_1111);
        @(negedge clk);
        check("t6_lat3", 128'(rd_dout), 128'hDEAD_BEEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
